floppy_sd_responder: RTL and testbench
======================================

FLOPPY_SD_RESPONDER -- requirements
Module: floppy_sd_responder
Parameters
REQ-001 SHALL have MAX_LBA, default 11'd1600, first out-of-range sector index (819200-byte image).
REQ-002 SHALL have WR_LAT, default 2, cycles from sd_addr update to sampling sd_data_out.
Interface
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst  in  1  reset rst, synchronous, active-high; clock clk.
REQ-005 sd_lba  in  11  sector index of request.
REQ-006 sd_rd / sd_wr  in  2 each  per-drive read/write request levels; bit0 = int, bit1 = ext drive.
REQ-007 sd_busy  out  1  transaction in progress.
REQ-008 sd_done  out  1  one-cycle pulse at transaction end.
REQ-009 sd_err  out  1  one-cycle pulse with sd_done on abort/out-of-range.
REQ-010 sd_addr  out  9  byte index within sector.
REQ-011 sd_data_en  out  1  read byte valid strobe.
REQ-012 sd_data_in  out  8  read byte to initiator.
REQ-013 sd_data_out  in  8  write byte from initiator, registered by initiator from sd_addr.
REQ-014 host_rd / host_wr  out  1 each  host sector request levels.
REQ-015 host_drive  out  1  latched drive; host_lba  out  11  latched sector.
REQ-016 host_ack  in  1  host owns transfer while high.
REQ-017 host_din  in  8 / host_din_strobe  in  1  host read byte and valid strobe.
REQ-018 host_dout  out  8 / host_dout_strobe  in  1  write byte to host; strobe = host consumed it.
Function
REQ-019 States SHALL be IDLE, REQ, RD_STREAM, WR_FETCH, WR_HOLD, ACK_LOW, ZERO, DONE.
REQ-020 IDLE: accept when sd_rd|sd_wr nonzero; priority sd_rd over sd_wr, bit0 over bit1; latch sd_lba, drive, direction; sd_busy=1 next cycle and held until DONE.
REQ-021 Acceptance with sd_lba >= MAX_LBA SHALL go to ZERO, no host request.
REQ-022 ZERO: read = 512 sd_data_en pulses, one per cycle, sd_data_in=0, sd_addr 0..511; write = discard; then DONE with sd_err=1.
REQ-023 REQ: host_rd or host_wr held high until host_ack=1, then dropped; read -> RD_STREAM, write -> WR_FETCH with sd_addr=0.
REQ-024 RD_STREAM: each host_din_strobe SHALL produce, next cycle, sd_data_en=1 for one cycle, sd_data_in=host_din, sd_addr=byte count; count increments after each byte.
REQ-025 Byte 511 delivered -> ACK_LOW; strobes beyond 512 ignored.
REQ-026 WR_FETCH: wait WR_LAT cycles after sd_addr update, capture sd_data_out into host_dout -> WR_HOLD.
REQ-027 WR_HOLD: on host_dout_strobe, byte 511 -> ACK_LOW, else sd_addr+1 -> WR_FETCH.
REQ-028 ACK_LOW: wait host_ack=0 -> DONE.
REQ-029 host_ack falling before 512 bytes SHALL abort -> DONE with sd_err=1; partial read bytes remain delivered.
REQ-030 DONE: sd_done=1 one cycle, sd_busy=0 same cycle, -> IDLE; new request accepted no earlier than next cycle.
REQ-031 Requests arriving while busy SHALL be ignored until IDLE; sd_lba changes after acceptance SHALL not affect host_lba.
REQ-032 sd_addr SHALL wrap only via reset to 0 at acceptance; counter width 10 bits internally to detect 512.
REQ-033 host_din_strobe outside RD_STREAM and host_dout_strobe outside WR_HOLD SHALL be ignored.
Reset
REQ-034 rst SHALL force IDLE; sd_busy, sd_done, sd_err, sd_data_en, host_rd, host_wr = 0; sd_addr, sd_data_in, host_dout, host_lba = 0; host_drive = 0.
REQ-035 rst mid-transaction SHALL drop host request and busy in the same reset cycle; no sd_done issued.
Verification
REQ-036 sd_rd=01, sd_lba=5; host acks, strobes bytes 0x00..0xFF twice -> host_lba=5, host_drive=0, 512 sd_data_en pulses, sd_addr 0..511, data matches, one sd_done, sd_err=0.
REQ-037 sd_wr=10, sd_lba=100; initiator returns sd_data_out=sd_addr[7:0] after one cycle -> host_wr=1, host_drive=1, host sees 512 bytes equal index[7:0], sd_done pulse.
REQ-038 sd_rd=01 and sd_wr=10 same cycle -> read of drive 0 only; host_wr never asserted.
REQ-039 sd_rd=01, sd_lba=1600 -> no host_rd, 512 zero bytes in 512 consecutive cycles, sd_done with sd_err=1.
REQ-040 Read, host_ack drops after 100 strobes -> 100 sd_data_en pulses, sd_done with sd_err=1, return to IDLE.
REQ-041 rst asserted at byte 200 of write -> next cycle all outputs at reset values; subsequent sd_rd accepted normally.

Source files
------------

// File: rtl/floppy_sd_responder_if.sv
// Bus bundle between a sector initiator (sd_* side) and a host sector server (host_* side).
// slave  : view of the responder (floppy_sd_responder).
// master : view of the environment driving the initiator and host sides.
// sd_*   : sector request, status pulses, byte index and byte streams to/from the initiator.
// host_* : sector request levels, latched drive/LBA, ack level and byte streams with strobes.
interface floppy_sd_responder_if;
  logic [10:0] sd_lba;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic        sd_busy;
  logic        sd_done;
  logic        sd_err;
  logic [8:0]  sd_addr;
  logic        sd_data_en;
  logic [7:0]  sd_data_in;
  logic [7:0]  sd_data_out;
  logic        host_rd;
  logic        host_wr;
  logic        host_drive;
  logic [10:0] host_lba;
  logic        host_ack;
  logic [7:0]  host_din;
  logic        host_din_strobe;
  logic [7:0]  host_dout;
  logic        host_dout_strobe;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_data_out, host_ack, host_din, host_din_strobe,
           host_dout_strobe,
    output sd_busy, sd_done, sd_err, sd_addr, sd_data_en, sd_data_in, host_rd, host_wr,
           host_drive, host_lba, host_dout
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_data_out, host_ack, host_din, host_din_strobe,
           host_dout_strobe,
    input  sd_busy, sd_done, sd_err, sd_addr, sd_data_en, sd_data_in, host_rd, host_wr,
           host_drive, host_lba, host_dout
  );
endinterface

// File: rtl/floppy_sd_responder.sv
// Floppy sector responder: accepts per-drive 512-byte sector read/write requests from an
// initiator and relays them to a host, streaming bytes in both directions. Requests for a
// sector at or beyond MAX_LBA are answered locally with zeros (read) or discarded (write)
// and flagged with sd_err.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - floppy_sd_responder_if.slave: initiator (sd_*) and host (host_*) signals
module floppy_sd_responder #(
  parameter logic [10:0] MAX_LBA = 11'd1600,
  parameter int unsigned WR_LAT  = 2
) (
  input logic                    clk,
  input logic                    rst,
  floppy_sd_responder_if.slave   bus
);

  localparam logic [7:0] LatLast = (WR_LAT > 0) ? 8'(WR_LAT - 1) : 8'd0;

  typedef enum logic [2:0] {
    StIdle, StReq, StRdStream, StWrFetch, StWrHold, StAckLow, StZero, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        data_en_q, data_en_d;
  logic [7:0]  data_in_q, data_in_d;
  logic [8:0]  addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;      // byte index; bit 9 marks a full sector
  logic [7:0]  lat_q, lat_d;
  logic        host_rd_q, host_rd_d;
  logic        host_wr_q, host_wr_d;
  logic        drive_q, drive_d;
  logic [10:0] lba_q, lba_d;
  logic        wr_dir_q, wr_dir_d;
  logic [7:0]  dout_q, dout_d;

  logic finish, finish_err;
  logic acc_rd;
  assign acc_rd = |bus.sd_rd;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    data_en_d  = 1'b0;
    data_in_d  = data_in_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    host_rd_d  = host_rd_q;
    host_wr_d  = host_wr_q;
    drive_d    = drive_q;
    lba_d      = lba_q;
    wr_dir_d   = wr_dir_q;
    dout_d     = dout_q;
    finish     = 1'b0;
    finish_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (acc_rd || (|bus.sd_wr)) begin
          busy_d   = 1'b1;
          lba_d    = bus.sd_lba;
          addr_d   = '0;
          cnt_d    = '0;
          lat_d    = '0;
          // Reads win over writes; within a direction drive 0 wins over drive 1.
          wr_dir_d = ~acc_rd;
          drive_d  = acc_rd ? ~bus.sd_rd[0] : ~bus.sd_wr[0];
          if (bus.sd_lba >= MAX_LBA) begin
            state_d = StZero;
          end else begin
            state_d   = StReq;
            host_rd_d = acc_rd;
            host_wr_d = ~acc_rd;
          end
        end
      end
      StReq: begin
        if (bus.host_ack) begin
          host_rd_d = 1'b0;
          host_wr_d = 1'b0;
          addr_d    = '0;
          cnt_d     = '0;
          lat_d     = '0;
          state_d   = wr_dir_q ? StWrFetch : StRdStream;
        end
      end
      StRdStream: begin
        if (bus.host_din_strobe) begin
          data_en_d = 1'b1;
          data_in_d = bus.host_din;
          addr_d    = cnt_q[8:0];
          cnt_d     = cnt_q + 10'd1;
          if (cnt_q == 10'd511) state_d = StAckLow;
        end
        if (!bus.host_ack && !(bus.host_din_strobe && cnt_q == 10'd511)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      StWrFetch: begin
        // The initiator registers sd_data_out from sd_addr, so give it WR_LAT cycles.
        if (lat_q >= LatLast) begin
          dout_d  = bus.sd_data_out;
          state_d = StWrHold;
        end else begin
          lat_d = lat_q + 8'd1;
        end
        if (!bus.host_ack) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      StWrHold: begin
        if (bus.host_dout_strobe) begin
          if (cnt_q == 10'd511) begin
            state_d = StAckLow;
          end else begin
            cnt_d   = cnt_q + 10'd1;
            addr_d  = cnt_q[8:0] + 9'd1;
            lat_d   = '0;
            state_d = StWrFetch;
          end
        end else if (!bus.host_ack) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      StAckLow: begin
        if (!bus.host_ack) finish = 1'b1;
      end
      StZero: begin
        if (wr_dir_q || cnt_q[9]) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          data_en_d = 1'b1;
          data_in_d = 8'd0;
          addr_d    = cnt_q[8:0];
          cnt_d     = cnt_q + 10'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Status pulses are registered so sd_done/sd_err coincide with the DONE state.
    if (finish) begin
      state_d = StDone;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      err_d   = finish_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      data_en_q <= 1'b0;
      data_in_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      lat_q     <= '0;
      host_rd_q <= 1'b0;
      host_wr_q <= 1'b0;
      drive_q   <= 1'b0;
      lba_q     <= '0;
      wr_dir_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      data_en_q <= data_en_d;
      data_in_q <= data_in_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      host_rd_q <= host_rd_d;
      host_wr_q <= host_wr_d;
      drive_q   <= drive_d;
      lba_q     <= lba_d;
      wr_dir_q  <= wr_dir_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.sd_busy    = busy_q;
  assign bus.sd_done    = done_q;
  assign bus.sd_err     = err_q;
  assign bus.sd_addr    = addr_q;
  assign bus.sd_data_en = data_en_q;
  assign bus.sd_data_in = data_in_q;
  assign bus.host_rd    = host_rd_q;
  assign bus.host_wr    = host_wr_q;
  assign bus.host_drive = drive_q;
  assign bus.host_lba   = lba_q;
  assign bus.host_dout  = dout_q;

endmodule

// File: tb/tb_floppy_sd_responder.sv
// Self-checking bench for floppy_sd_responder: read/write sector transfers, request
// priority, out-of-range sectors, host abort and mid-transfer reset.
module tb_floppy_sd_responder;

  logic clk;
  logic rst;
  floppy_sd_responder_if sd_if ();

  floppy_sd_responder #(
    .MAX_LBA (11'd1600),
    .WR_LAT  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int hrd_cyc  = 0;
  int hwr_cyc  = 0;
  logic [16:0] exp_q[$];   // {sd_addr, sd_data_in}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Initiator registers the write byte from sd_addr (one cycle of latency).
  always @(posedge clk) sd_if.sd_data_out <= sd_if.sd_addr[7:0];

  // Output monitor: scoreboard pop on each read strobe, pulse and level counters.
  always @(negedge clk) begin
    logic [16:0] e;
    if (sd_if.sd_data_en === 1'b1) begin
      en_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_extra_byte", {23'd0, sd_if.sd_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check_eq("rd_addr", {23'd0, sd_if.sd_addr}, {23'd0, e[16:8]});
        check_eq("rd_data", {24'd0, sd_if.sd_data_in}, {24'd0, e[7:0]});
      end
    end
    if (sd_if.sd_done === 1'b1) begin
      done_cnt++;
      if (sd_if.sd_err === 1'b1) err_cnt++;
    end
    if (sd_if.host_rd === 1'b1) hrd_cyc++;
    if (sd_if.host_wr === 1'b1) hwr_cyc++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, sd_if.sd_busy}, 0);
    check_eq({tag, "_done"}, {31'd0, sd_if.sd_done}, 0);
    check_eq({tag, "_err"}, {31'd0, sd_if.sd_err}, 0);
    check_eq({tag, "_data_en"}, {31'd0, sd_if.sd_data_en}, 0);
    check_eq({tag, "_host_rd"}, {31'd0, sd_if.host_rd}, 0);
    check_eq({tag, "_host_wr"}, {31'd0, sd_if.host_wr}, 0);
    check_eq({tag, "_addr"}, {23'd0, sd_if.sd_addr}, 0);
    check_eq({tag, "_data_in"}, {24'd0, sd_if.sd_data_in}, 0);
    check_eq({tag, "_host_dout"}, {24'd0, sd_if.host_dout}, 0);
    check_eq({tag, "_host_lba"}, {21'd0, sd_if.host_lba}, 0);
    check_eq({tag, "_host_drive"}, {31'd0, sd_if.host_drive}, 0);
  endtask

  task automatic request(input logic [1:0] rd, input logic [1:0] wr, input logic [10:0] lba);
    sd_if.sd_rd  = rd;
    sd_if.sd_wr  = wr;
    sd_if.sd_lba = lba;
    tick();
    sd_if.sd_rd  = 2'b00;
    sd_if.sd_wr  = 2'b00;
    sd_if.sd_lba = 11'h7FF;  // later changes must not reach host_lba
  endtask

  task automatic wait_host_rd(input string tag);
    for (int k = 0; k < 20 && sd_if.host_rd !== 1'b1; k++) tick();
    check_eq(tag, {31'd0, sd_if.host_rd}, 1);
  endtask

  task automatic wait_done(input string tag, input int base);
    for (int k = 0; k < 3000 && done_cnt == base; k++) tick();
    check_eq(tag, done_cnt - base, 1);
  endtask

  // Write sector from initiator to host; returns after n host strobes (strobe left high).
  task automatic do_write(input logic [10:0] lba, input int n);
    request(2'b00, 2'b10, lba);
    for (int k = 0; k < 20 && sd_if.host_wr !== 1'b1; k++) tick();
    check_eq("wr_host_wr", {31'd0, sd_if.host_wr}, 1);
    check_eq("wr_host_drive", {31'd0, sd_if.host_drive}, 1);
    check_eq("wr_host_lba", {21'd0, sd_if.host_lba}, {21'd0, lba});
    check_eq("wr_busy", {31'd0, sd_if.sd_busy}, 1);
    sd_if.host_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat (3) begin
        tick();
        sd_if.host_dout_strobe = 1'b0;
      end
      check_eq("wr_byte", {24'd0, sd_if.host_dout}, i & 32'hFF);
      sd_if.host_dout_strobe = 1'b1;
    end
  endtask

  int base_done, base_err, base_en, base_hrd, base_hwr, run;

  task automatic snap();
    base_done = done_cnt;
    base_err  = err_cnt;
    base_en   = en_cnt;
    base_hrd  = hrd_cyc;
    base_hwr  = hwr_cyc;
  endtask

  initial begin
    rst = 1'b1;
    sd_if.sd_rd = '0;
    sd_if.sd_wr = '0;
    sd_if.sd_lba = '0;
    sd_if.host_ack = 1'b0;
    sd_if.host_din = '0;
    sd_if.host_din_strobe = 1'b0;
    sd_if.host_dout_strobe = 1'b0;
    repeat (3) tick();
    check_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Full read, drive 0, sector 5: bytes 0x00..0xFF twice.
    snap();
    request(2'b01, 2'b00, 11'd5);
    check_eq("rd_busy", {31'd0, sd_if.sd_busy}, 1);
    wait_host_rd("rd_host_rd");
    check_eq("rd_host_lba", {21'd0, sd_if.host_lba}, 5);
    check_eq("rd_host_drive", {31'd0, sd_if.host_drive}, 0);
    sd_if.host_ack = 1'b1;
    for (int i = 0; i < 515; i++) begin
      tick();
      sd_if.host_din_strobe = 1'b1;
      sd_if.host_din = 8'(i);
      if (i < 512) exp_q.push_back({9'(i), 8'(i)});
    end
    tick();
    sd_if.host_din_strobe = 1'b0;
    sd_if.host_ack = 1'b0;
    wait_done("rd_done", base_done);
    check_eq("rd_busy_at_done", {31'd0, sd_if.sd_busy}, 0);
    tick();
    check_eq("rd_bytes", en_cnt - base_en, 512);
    check_eq("rd_err", err_cnt - base_err, 0);
    check_eq("rd_sb_empty", exp_q.size(), 0);

    // Full write, drive 1, sector 100.
    snap();
    do_write(11'd100, 512);
    tick();
    sd_if.host_dout_strobe = 1'b0;
    sd_if.host_ack = 1'b0;
    wait_done("wr_done", base_done);
    tick();
    check_eq("wr_err", err_cnt - base_err, 0);

    // Read and write drive requests together; host aborts after 100 bytes.
    snap();
    request(2'b01, 2'b10, 11'd9);
    wait_host_rd("pri_host_rd");
    check_eq("pri_host_drive", {31'd0, sd_if.host_drive}, 0);
    sd_if.host_ack = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      sd_if.host_din_strobe = 1'b1;
      sd_if.host_din = 8'(i * 7 + 3);
      exp_q.push_back({9'(i), 8'(i * 7 + 3)});
    end
    tick();
    sd_if.host_din_strobe = 1'b0;
    sd_if.host_ack = 1'b0;
    wait_done("abort_done", base_done);
    tick();
    check_eq("abort_err", err_cnt - base_err, 1);
    check_eq("abort_bytes", en_cnt - base_en, 100);
    check_eq("pri_no_host_wr", hwr_cyc - base_hwr, 0);
    check_eq("abort_sb_empty", exp_q.size(), 0);
    check_eq("abort_idle", {31'd0, sd_if.sd_busy}, 0);

    // Out-of-range read: zeros locally, no host request.
    snap();
    for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), 8'd0});
    request(2'b01, 2'b00, 11'd1600);
    for (int k = 0; k < 20 && sd_if.sd_data_en !== 1'b1; k++) tick();
    run = 0;
    repeat (512) begin
      if (sd_if.sd_data_en === 1'b1) run++;
      tick();
    end
    check_eq("oor_consecutive", run, 512);
    wait_done("oor_done", base_done);
    tick();
    check_eq("oor_err", err_cnt - base_err, 1);
    check_eq("oor_no_host_rd", hrd_cyc - base_hrd, 0);
    check_eq("oor_bytes", en_cnt - base_en, 512);
    check_eq("oor_sb_empty", exp_q.size(), 0);

    // Reset at byte 200 of a write, then a normal read request.
    snap();
    do_write(11'd300, 200);
    tick();
    sd_if.host_dout_strobe = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outs("midrst");
    rst = 1'b0;
    sd_if.host_ack = 1'b0;
    tick();
    check_eq("midrst_no_done", done_cnt - base_done, 0);
    snap();
    request(2'b01, 2'b00, 11'd7);
    wait_host_rd("post_rst_host_rd");
    check_eq("post_rst_lba", {21'd0, sd_if.host_lba}, 7);
    sd_if.host_ack = 1'b1;
    tick();
    tick();
    sd_if.host_ack = 1'b0;
    wait_done("post_rst_done", base_done);
    tick();
    check_eq("post_rst_err", err_cnt - base_err, 1);
    check_eq("post_rst_bytes", en_cnt - base_en, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
